// File: rtl/idx_to_oh_skid_pkg.sv
// Shared types and decode helper for the index-to-one-hot decoder and the blocks
// that reuse its decode. Types are sized for the widest supported decoder.
package idx_to_oh_skid_pkg;

  localparam int unsigned OH_MAX_WIDTH  = 64;
  localparam int unsigned IDX_MAX_WIDTH = $clog2(OH_MAX_WIDTH);

  typedef logic [OH_MAX_WIDTH-1:0]  oh_vec_t;
  typedef logic [IDX_MAX_WIDTH-1:0] idx_t;

  // Narrower decoders leave the upper one_hot/idx bits at constant zero.
  typedef struct packed {
    oh_vec_t one_hot;
    idx_t    idx;
    logic    range_err;
  } decode_entry_t;

  // Encoding is {skid.valid, main.valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

  function automatic decode_entry_t DECODE_OH(input idx_t idx, input int unsigned oh_width);
    decode_entry_t e;
    e.idx       = idx;
    e.range_err = (32'(idx) >= oh_width);
    e.one_hot   = e.range_err ? '0 : (oh_vec_t'(1) << idx);
    return e;
  endfunction

endpackage

// File: rtl/idx_to_oh_skid_buffer_2.sv
// Generic 2-entry valid/ready register slice: main entry drives the outputs from
// flops, skid entry absorbs the one item that arrives while main is stalled.
module skid_buffer_2
  import idx_to_oh_skid_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic [1:0]       state_bits;
  logic             m_vld, s_vld;
  logic             in_fire, out_fire;

  assign state_bits = state_q;
  assign m_vld      = state_bits[0];
  assign s_vld      = state_bits[1];
  assign in_fire    = in_valid && in_ready_q;
  assign out_fire   = m_vld && out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d  = ST_ONE;
          m_data_d = in_data;
        end
      end
      ST_ONE: begin
        // Simultaneous in/out: the current item leaves and main reloads in place.
        if (in_fire && out_fire) begin
          m_data_d = in_data;
        end else if (in_fire) begin
          state_d  = ST_FULL;
          s_data_d = in_data;
        end else if (out_fire) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d  = ST_ONE;
          m_data_d = s_data_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
    end
  end

  // Skid data is only ever read while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s_data_q <= s_data_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_vld;
  assign out_data  = m_data_q;

  a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
    state_bits != 2'b10);

  a_ready_tracks_skid: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q == !s_vld);

  a_no_accept_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    s_vld |-> !in_fire);

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_vld && !out_ready) |=> (m_vld && $stable(m_data_q)));

endmodule

// File: rtl/idx_to_oh_skid.sv
// Streaming index-to-one-hot decoder: decodes at capture time and presents
// {one_hot, idx, range_err} through a fully registered 2-entry skid buffer.
module idx_to_oh_skid
  import idx_to_oh_skid_pkg::*;
#(
  parameter int unsigned OH_WIDTH      = 4,
  parameter int unsigned IDX_WIDTH     = $clog2(OH_WIDTH),
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_WIDTH-1:0]     in_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OH_WIDTH-1:0]      out_one_hot,
  output logic [IDX_WIDTH-1:0]     out_idx,
  output logic                     out_range_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned ENTRY_W = $bits(decode_entry_t);

  if (OH_WIDTH < 2 || OH_WIDTH > OH_MAX_WIDTH ||
      IDX_WIDTH < $clog2(OH_WIDTH) || IDX_WIDTH > IDX_MAX_WIDTH) begin : g_bad_param
    $error("idx_to_oh_skid: unsupported OH_WIDTH/IDX_WIDTH combination");
  end

  decode_entry_t          dec_entry;
  decode_entry_t          out_ent;
  logic [ENTRY_W-1:0]     buf_out;
  logic                   in_fire;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                   unused_ent;

  assign dec_entry = DECODE_OH(IDX_MAX_WIDTH'(in_idx), OH_WIDTH);
  assign in_fire   = in_valid && in_ready;

  skid_buffer_2 #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_ent       = buf_out;
  assign out_one_hot   = out_ent.one_hot[OH_WIDTH-1:0];
  assign out_idx       = out_ent.idx[IDX_WIDTH-1:0];
  assign out_range_err = out_ent.range_err;
  assign unused_ent    = ^out_ent;

  // Counts accepted out-of-range indices, holding at all-ones rather than wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_fire && dec_entry.range_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

  a_err_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
    1'b1 |=> (err_cnt_q >= $past(err_cnt_q)));

  a_err_implies_zero_oh: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_range_err) |-> (out_one_hot == '0));

endmodule

// File: tb/tb_idx_to_oh_skid.sv
// Scoreboard bench: a power-of-two decoder (4 lanes) and a non-power-of-two
// decoder (5 lanes, 2-bit error counter) checked against a behavioural model.
module tb_idx_to_oh_skid;

  localparam int OHA        = 4;
  localparam int IWA        = 2;
  localparam int EWA        = 8;
  localparam int OHB        = 5;
  localparam int IWB        = 3;
  localparam int EWB        = 2;
  localparam int N_ITEMS    = 10000;
  localparam int CYC_BUDGET = 60000;

  typedef struct {
    logic [63:0] oh;
    int          idx;
    bit          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           a_in_valid = 1'b0;
  logic           a_out_ready = 1'b1;
  logic [IWA-1:0] a_in_idx = '0;
  logic           a_in_ready, a_out_valid, a_out_err;
  logic [OHA-1:0] a_out_oh;
  logic [IWA-1:0] a_out_idx;
  logic [EWA-1:0] a_err_cnt;

  logic           b_in_valid = 1'b0;
  logic           b_out_ready = 1'b1;
  logic [IWB-1:0] b_in_idx = '0;
  logic           b_in_ready, b_out_valid, b_out_err;
  logic [OHB-1:0] b_out_oh;
  logic [IWB-1:0] b_out_idx;
  logic [EWB-1:0] b_err_cnt;

  idx_to_oh_skid #(.OH_WIDTH(OHA), .IDX_WIDTH(IWA), .ERR_CNT_WIDTH(EWA)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(a_in_idx),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_one_hot(a_out_oh),
    .out_idx(a_out_idx), .out_range_err(a_out_err), .err_count(a_err_cnt)
  );

  idx_to_oh_skid #(.OH_WIDTH(OHB), .IDX_WIDTH(IWB), .ERR_CNT_WIDTH(EWB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_one_hot(b_out_oh),
    .out_idx(b_out_idx), .out_range_err(b_out_err), .err_count(b_err_cnt)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t mon_ea, mon_eb;
  int   exp_err_a = 0;
  int   exp_err_b = 0;
  int   acc_a = 0;
  int   acc_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: lane idx set when it exists, otherwise nothing set and flagged.
  function automatic exp_t model(input int idx, input int width);
    exp_t e;
    e.idx = idx;
    e.err = (idx >= width);
    e.oh  = e.err ? 64'd0 : (64'd1 << idx);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input int idx);
    a_in_valid = v;
    a_in_idx   = IWA'(idx);
    if (v && a_in_ready) begin
      qa.push_back(model(idx, OHA));
      acc_a++;
      if (idx >= OHA && exp_err_a < (1 << EWA) - 1) exp_err_a++;
    end
  endtask

  task automatic drive_b(input bit v, input int idx);
    b_in_valid = v;
    b_in_idx   = IWB'(idx);
    if (v && b_in_ready) begin
      qb.push_back(model(idx, OHB));
      acc_b++;
      if (idx >= OHB && exp_err_b < (1 << EWB) - 1) exp_err_b++;
    end
  endtask

  // Monitors: an output transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check("A spurious out_valid", a_out_valid, 1'b0);
      end else begin
        mon_ea = qa.pop_front();
        check("A out_one_hot", a_out_oh, mon_ea.oh);
        check("A out_idx", a_out_idx, mon_ea.idx);
        check("A out_range_err", a_out_err, mon_ea.err);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        check("B spurious out_valid", b_out_valid, 1'b0);
      end else begin
        mon_eb = qb.pop_front();
        check("B out_one_hot", b_out_oh, mon_eb.oh);
        check("B out_idx", b_out_idx, mon_eb.idx);
        check("B out_range_err", b_out_err, mon_eb.err);
      end
    end
  end

  initial begin
    int cyc;

    // Reset, then a single index
    repeat (3) step();
    check("reset A out_valid", a_out_valid, 1'b0);
    check("reset A out_one_hot", a_out_oh, 0);
    check("reset A out_idx", a_out_idx, 0);
    check("reset A out_range_err", a_out_err, 1'b0);
    check("reset A err_count", a_err_cnt, 0);
    check("reset B out_valid", b_out_valid, 1'b0);
    check("reset B err_count", b_err_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("A in_ready after reset", a_in_ready, 1'b1);
    drive_a(1'b1, 2);
    step();
    check("single out_valid", a_out_valid, 1'b1);
    check("single out_one_hot", a_out_oh, 4'b0100);
    check("single out_idx", a_out_idx, 2);
    check("single out_range_err", a_out_err, 1'b0);
    drive_a(1'b0, 0);
    step();
    check("single drained", a_out_valid, 1'b0);

    // Full-throughput stream
    for (int i = 0; i < OHA; i++) begin
      drive_a(1'b1, i);
      check("stream in_ready", a_in_ready, 1'b1);
      step();
      check("stream out_valid", a_out_valid, 1'b1);
      check("stream out_one_hot", a_out_oh, 64'd1 << i);
    end
    drive_a(1'b0, 0);
    step();
    check("stream drained", a_out_valid, 1'b0);

    // Backpressure fills both entries
    a_out_ready = 1'b0;
    drive_a(1'b1, 1);
    step();
    check("bp first held", a_out_oh, 4'b0010);
    check("bp in_ready one", a_in_ready, 1'b1);
    drive_a(1'b1, 3);
    step();
    check("bp in_ready full", a_in_ready, 1'b0);
    check("bp still first", a_out_oh, 4'b0010);
    drive_a(1'b0, 0);
    step();
    check("bp hold", a_out_oh, 4'b0010);
    check("bp hold in_ready", a_in_ready, 1'b0);
    a_out_ready = 1'b1;
    step();
    check("bp second", a_out_oh, 4'b1000);
    check("bp in_ready reopened", a_in_ready, 1'b1);
    step();
    check("bp drained", a_out_valid, 1'b0);

    // Out-of-range on the 5-lane decoder, then counter saturation
    drive_b(1'b1, 4);
    step();
    check("B lane4 one_hot", b_out_oh, 5'b10000);
    drive_b(1'b1, 6);
    step();
    check("B oor out_one_hot", b_out_oh, 5'b00000);
    check("B oor out_range_err", b_out_err, 1'b1);
    check("B oor out_idx", b_out_idx, 6);
    check("B oor err_count", b_err_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b1, 6);
      step();
    end
    drive_b(1'b0, 0);
    step();
    check("B err_count saturated", b_err_cnt, 3);
    check("B err model", b_err_cnt, exp_err_b);
    repeat (2) step();
    check("B drained", b_out_valid, 1'b0);

    // Asynchronous reset while both entries are occupied
    a_out_ready = 1'b0;
    drive_a(1'b1, 1);
    step();
    drive_a(1'b1, 2);
    step();
    drive_a(1'b0, 0);
    check("pre-reset full", a_in_ready, 1'b0);
    check("pre-reset out_valid", a_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", a_out_valid, 1'b0);
    check("async reset B err_count", b_err_cnt, 0);
    qa.delete();
    qb.delete();
    exp_err_a = 0;
    exp_err_b = 0;
    step();
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check("post-reset in_ready", a_in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("no stale item", a_out_valid, 1'b0);
    end

    // Random valid/ready traffic on both decoders
    acc_a = 0;
    acc_b = 0;
    cyc   = 0;
    while ((acc_a < N_ITEMS || acc_b < N_ITEMS) && cyc < CYC_BUDGET) begin
      check("rnd A in_ready", a_in_ready, qa.size() < 2);
      check("rnd A out_valid", a_out_valid, qa.size() > 0);
      check("rnd A err_count", a_err_cnt, exp_err_a);
      check("rnd B in_ready", b_in_ready, qb.size() < 2);
      check("rnd B out_valid", b_out_valid, qb.size() > 0);
      check("rnd B err_count", b_err_cnt, exp_err_b);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      drive_a($urandom_range(0, 9) < 7, $urandom_range(0, (1 << IWA) - 1));
      drive_b($urandom_range(0, 9) < 7, $urandom_range(0, (1 << IWB) - 1));
      step();
      cyc++;
    end
    check("random item budget reached", (acc_a >= N_ITEMS) && (acc_b >= N_ITEMS), 1'b1);

    // Drain
    drive_a(1'b0, 0);
    drive_b(1'b0, 0);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) step();
    step();
    check("A drained at end", qa.size(), 0);
    check("B drained at end", qb.size(), 0);
    check("A idle at end", a_out_valid, 1'b0);
    check("B idle at end", b_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
